nibble_serial_addsub32: RTL and testbench



---
 rtl/alu32_pkg.sv | 15 +
 rtl/cla4.sv | 28 ++
 rtl/nibble_serial_addsub32.sv | 132 +++++++++++++
 tb/tb_nibble_serial_addsub32.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// Shared encodings for the nibble-serial 32-bit add/subtract unit.
package alu32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder; purely combinational nibble datapath.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum_c,
  output logic       co_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Carries expanded from generate/propagate, no ripple between bits.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    sum_c = p ^ c[3:0];
    co_c  = c[4];
  end

endmodule

// File: rtl/nibble_serial_addsub32.sv
// Multi-cycle add/subtract: one nibble per clock through a single cla4,
// carry kept in a register between nibbles, NZCV flags on completion.
module nibble_serial_addsub32
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = $clog2(NIB + 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sh, a_sh_nx;
  logic [WIDTH-1:0]   bx_sh, bx_sh_nx;
  logic               carry, carry_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0]   result_nx;
  logic               busy_nx, done_nx;
  logic               flag_n_nx, flag_z_nx, flag_c_nx, flag_v_nx;
  logic [NIB_W-1:0]   nib_sum;
  logic               nib_co;

  cla4 u_cla4 (
    .a     (a_sh[NIB_W-1:0]),
    .b     (bx_sh[NIB_W-1:0]),
    .ci    (carry),
    .sum_c (nib_sum),
    .co_c  (nib_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      bx_sh  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      state  <= state_nx;
      a_sh   <= a_sh_nx;
      bx_sh  <= bx_sh_nx;
      carry  <= carry_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      flag_n <= flag_n_nx;
      flag_z <= flag_z_nx;
      flag_c <= flag_c_nx;
      flag_v <= flag_v_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    a_sh_nx   = a_sh;
    bx_sh_nx  = bx_sh;
    carry_nx  = carry;
    cnt_nx    = cnt;
    result_nx = result;
    busy_nx   = busy;
    done_nx   = 1'b0;
    flag_n_nx = flag_n;
    flag_z_nx = flag_z;
    flag_c_nx = flag_c;
    flag_v_nx = flag_v;

    unique case (state)
      ST_IDLE: begin
        busy_nx = 1'b0;
        // Subtract is a + ~b + 1; the +1 enters as the initial carry.
        if (start) begin
          a_sh_nx   = a;
          bx_sh_nx  = (op == OP_SUB) ? ~b : b;
          carry_nx  = op;
          cnt_nx    = '0;
          result_nx = '0;
          busy_nx   = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_nx[NIB_W*int'(cnt) +: NIB_W] = nib_sum;
        carry_nx = nib_co;
        cnt_nx   = cnt + CNT_W'(1);
        a_sh_nx  = a_sh >> NIB_W;
        bx_sh_nx = bx_sh >> NIB_W;
        // Final nibble: shift registers still hold the operand MSBs here.
        if (cnt == CNT_W'(NIB - 1)) begin
          state_nx  = ST_DONE;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          flag_n_nx = result_nx[WIDTH-1];
          flag_z_nx = (result_nx == '0);
          flag_c_nx = nib_co;
          flag_v_nx = (a_sh[NIB_W-1] == bx_sh[NIB_W-1]) &&
                      (nib_sum[NIB_W-1] != a_sh[NIB_W-1]);
        end
      end
      ST_DONE: begin
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_addsub32.sv
// Directed and random checks of nibble_serial_addsub32 against an arithmetic model.
module tb_nibble_serial_addsub32;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;

  int total = 0;
  int bad   = 0;

  nibble_serial_addsub32 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {n, z, c, v, result} from plain wide arithmetic.
  function automatic logic [35:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    logic [31:0] r;
    logic        v;
    if (o) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else   full = {1'b0, x} + {1'b0, y};
    r = full[31:0];
    if (o) v = (x[31] != y[31]) && (r[31] != x[31]);
    else   v = (x[31] == y[31]) && (r[31] != x[31]);
    return {r[31], (r == 32'd0), full[32], v, r};
  endfunction

  task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input int p1, input int p2);
    logic [35:0] exp;
    int edges;
    int busy_cnt;
    bit got;
    exp = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    edges = 1; busy_cnt = 0; got = 0;
    while (!got && edges < 30) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        if (edges == p1 || edges == p2) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges++;
      end
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " edges"}, 32'(edges), 32'd9);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " result"}, result, exp[31:0]);
    check({tag, " nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(exp[35:32]));
    @(negedge clk);
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " result_held"}, result, exp[31:0]);
  endtask

  initial begin
    logic [35:0] exp;
    int last_done;
    int n_done;
    int busy_hi;
    bit prev_done;

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    reset = 1'b0;

    run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, -1, -1);
    run_op("sub_borrow", 1'b1, 32'h0000_0005, 32'h0000_0007, -1, -1);
    run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, -1, -1);
    run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, -1, -1);

    // Start pulses mid-run must be ignored.
    run_op("ignore_start", 1'b0, 32'h1234_5678, 32'h1111_1111, 3, 8);
    busy_hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) busy_hi++;
    end
    check("ignore_start no_second_op", 32'(busy_hi), 32'd0);
    check("ignore_start result_final", result, 32'h2345_6789);

    // Abort in RUN after four nibbles.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_abort", 1'b0, 32'h0000_000F, 32'h0000_0001, -1, -1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] rx, ry;
      logic ro;
      rx = $urandom; ry = $urandom; ro = 1'($urandom);
      if (i % 5 == 0) ry = rx;
      run_op($sformatf("rand%0d", i), ro, rx, ry, -1, -1);
    end

    // Start held high: one accept every 10 cycles, 1-cycle done pulses.
    exp = model(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    last_done = -1; n_done = 0; prev_done = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("b2b done_width", 32'(prev_done), 32'd0);
        check("b2b result", result, exp[31:0]);
        if (last_done >= 0) check("b2b spacing", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        n_done++;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b done_count", 32'(n_done), 32'd4);
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
